// File: rtl/hnoc_pkg.sv
// hnoc_pkg
//   Shared constants and types for the PE-to-link arbitration slice.
//   DATA_W    : default flit width
//   NUM_PE    : default number of requesting PE ports
//   PE_ADDR_W : width of the destination field carried in the flit MSBs
//   SRC_W     : width of the source-index field reported with each flit
//   flit_t    : flit layout (destination in the top PE_ADDR_W bits)
package hnoc_pkg;

  localparam int DATA_W    = 32;
  localparam int NUM_PE    = 4;
  localparam int PE_ADDR_W = 8;
  localparam int SRC_W     = 2;

  typedef struct packed {
    logic [PE_ADDR_W-1:0]        dest;
    logic [DATA_W-PE_ADDR_W-1:0] payload;
  } flit_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter with a registered "last granted" pointer.
//   Search starts at (last+1) mod NUM_PE and wraps; the pointer moves to the
//   winner only when advance is high (i.e. the grant was actually taken).
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset (pointer -> NUM_PE-1)
//   req     : per-port request vector
//   advance : commit the current winner as the new pointer
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : binary index of the winner (0 when no request)
module rr_arbiter #(
  parameter int NUM_PE = 4,
  parameter int IDX_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_PE-1:0] req,
  input  logic              advance,
  output logic [NUM_PE-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx
);

  logic [IDX_W-1:0] last_r;
  logic [IDX_W-1:0] idx_s;
  logic             found_s;

  // Rotating priority search: first requester after the last winner.
  always_comb begin
    gnt     = {NUM_PE{1'b0}};
    gnt_idx = {IDX_W{1'b0}};
    idx_s   = {IDX_W{1'b0}};
    found_s = 1'b0;
    for (int i = 1; i <= NUM_PE; i++) begin
      idx_s = IDX_W'((int'(last_r) + i) % NUM_PE);
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        gnt_idx = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      gnt[gnt_idx] = 1'b1;
    end else begin
      gnt = {NUM_PE{1'b0}};
    end
  end

  // Pointer register: reset gives port 0 first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= IDX_W'(NUM_PE - 1);
    end else if (advance && found_s) begin
      last_r <= gnt_idx;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/pe_arbiter.sv
// pe_arbiter
//   Merges NUM_PE flit streams onto one shared link through a single output
//   register, round-robin fair, one flit per cycle, with per-port saturating
//   accepted-flit counters.
// Ports:
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   i_data        : packed input flits, port k at [k*DATA_W +: DATA_W]
//   i_data_valid  : per-port flit valid
//   o_data_ready  : per-port accept (at most one bit set)
//   o_data        : flit on the shared link (passed through unmodified)
//   o_data_valid  : o_data valid
//   i_data_ready  : shared-link accept
//   o_src         : source port of o_data
//   o_count       : packed per-port accepted-flit counters
module pe_arbiter
  import hnoc_pkg::*;
#(
  parameter int NUM_PE = hnoc_pkg::NUM_PE,
  parameter int DATA_W = hnoc_pkg::DATA_W,
  parameter int CNT_W  = 16
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PE*DATA_W-1:0] i_data,
  input  logic [NUM_PE-1:0]        i_data_valid,
  output logic [NUM_PE-1:0]        o_data_ready,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_data_valid,
  input  logic                     i_data_ready,
  output logic [SRC_W-1:0]         o_src,
  output logic [NUM_PE*CNT_W-1:0]  o_count
);

  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              load_en_s;
  logic              any_req_s;
  logic              grant_s;
  logic [NUM_PE-1:0] gnt_s;
  logic [IDX_W-1:0]  gnt_idx_s;
  logic [DATA_W-1:0] sel_flit_s;
  logic [DATA_W-1:0] data_r;
  logic [SRC_W-1:0]  src_r;
  logic              valid_r;
  logic [CNT_W-1:0]  cnt_r [NUM_PE];

  // The output register can take a new flit when empty or draining this cycle.
  assign load_en_s = ~valid_r | i_data_ready;
  assign any_req_s = |i_data_valid;
  assign grant_s   = load_en_s & any_req_s & ~rst;

  rr_arbiter #(
    .NUM_PE (NUM_PE),
    .IDX_W  (IDX_W)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (i_data_valid),
    .advance (grant_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  // Per-port accept: only the winner, only when the output register can load.
  always_comb begin
    o_data_ready = {NUM_PE{1'b0}};
    if (rst) begin
      o_data_ready = {NUM_PE{1'b0}};
    end else if (load_en_s) begin
      o_data_ready = gnt_s;
    end else begin
      o_data_ready = {NUM_PE{1'b0}};
    end
  end

  // One-hot AND-OR mux of the winning flit.
  always_comb begin
    sel_flit_s = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_PE; k++) begin
      sel_flit_s = sel_flit_s | (i_data[k*DATA_W +: DATA_W] & {DATA_W{gnt_s[k]}});
    end
  end

  // Output register: load on grant, empty when loadable with nothing to load,
  // otherwise hold (backpressure). Data/src keep their value when emptied.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r  <= {DATA_W{1'b0}};
      src_r   <= {SRC_W{1'b0}};
      valid_r <= 1'b0;
    end else if (grant_s) begin
      data_r  <= sel_flit_s;
      src_r   <= SRC_W'(gnt_idx_s);
      valid_r <= 1'b1;
    end else if (load_en_s) begin
      data_r  <= data_r;
      src_r   <= src_r;
      valid_r <= 1'b0;
    end else begin
      data_r  <= data_r;
      src_r   <= src_r;
      valid_r <= valid_r;
    end
  end

  // Saturating per-port counters of accepted input flits.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_PE; k++) begin
      if (rst) begin
        cnt_r[k] <= {CNT_W{1'b0}};
      end else if (o_data_ready[k] && i_data_valid[k]) begin
        cnt_r[k] <= sat_inc(cnt_r[k]);
      end else begin
        cnt_r[k] <= cnt_r[k];
      end
    end
  end

  for (genvar k = 0; k < NUM_PE; k++) begin : g_cnt
    assign o_count[k*CNT_W +: CNT_W] = cnt_r[k];
  end

  assign o_data       = data_r;
  assign o_src        = src_r;
  assign o_data_valid = valid_r;

endmodule

// File: doc/pe_arbiter.md
PE_ARBITER -- requirements
Module: pe_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_PE, default 4, number of requesting PE ports; DATA_W, default 32, flit width; CNT_W, default 16, per-port flit counter width.
REQ-002 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_data  input  NUM_PE*DATA_W  packed flits; port k SHALL occupy bits [k*DATA_W +: DATA_W].
REQ-005 i_data_valid  input  NUM_PE  per-port flit valid.
REQ-006 o_data_ready  output  NUM_PE  per-port accept; a flit SHALL transfer on port k when i_data_valid[k] & o_data_ready[k] at a clk edge.
REQ-007 o_data  output  DATA_W  arbitrated flit to the shared link.
REQ-008 o_data_valid  output  1  o_data valid.
REQ-009 i_data_ready  input  1  shared-link accept; transfer when o_data_valid & i_data_ready.
REQ-010 o_src  output  2  source port index of the flit on o_data.
REQ-011 o_count  output  NUM_PE*CNT_W  per-port accepted-flit counters, packed as in REQ-004.

Function
REQ-012 The block SHALL hold one output register (o_data, o_src, o_data_valid).
REQ-013 load_en SHALL be ~o_data_valid | i_data_ready.
REQ-014 At most one bit of o_data_ready SHALL be 1 in any cycle, and only while load_en is 1.
REQ-015 o_data_ready[k] SHALL be 1 iff load_en, i_data_valid[k], and k is the round-robin winner.
REQ-016 o_data_ready SHALL depend combinationally on i_data_valid, i_data_ready and registered state only.
REQ-017 Round-robin winner: the first valid port searched from (last+1) mod NUM_PE upward with wrap; last is the registered index of the most recent granted port.
REQ-018 last SHALL update to the winner only on a cycle where a transfer occurs per REQ-006.
REQ-019 last SHALL NOT change when no input is valid or when load_en is 0.
REQ-020 On a grant, the next cycle SHALL show o_data = winning flit, o_src = winner index, and o_data_valid = 1.
REQ-021 Latency: one cycle from input transfer to output valid.
REQ-022 Throughput: one flit per cycle sustained while i_data_ready = 1.
REQ-023 Simultaneous output drain and new grant in the same cycle SHALL load the new flit with no bubble.
REQ-024 With load_en = 1 and no input valid, o_data_valid SHALL fall to 0; o_data and o_src keep their last value.
REQ-025 While o_data_valid & ~i_data_ready, o_data and o_src SHALL be held stable.
REQ-026 The flit SHALL pass through unmodified; destination bits [DATA_W-1:DATA_W-8] are not interpreted.
REQ-027 A port's counter SHALL increment by 1 on each transfer from that port.
REQ-028 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 With one requester continuously valid, that port SHALL be granted every load_en cycle; no idle grants.

Reset
REQ-030 While rst = 1 at a clk edge, the following SHALL be cleared: o_data_valid = 0, o_data = 0, o_src = 0, all counters = 0, last = NUM_PE-1, so port 0 has first priority.
REQ-031 During rst, o_data_ready SHALL be all 0.
REQ-032 A flit held in the output register when rst asserts SHALL be discarded.
REQ-033 The first grant SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-034 Shared package hnoc_pkg SHALL hold DATA_W = 32, NUM_PE = 4, PE_ADDR_W = 8 (destination field width), and the flit type.
REQ-035 One sub-module rr_arbiter SHALL implement REQ-017/018.
REQ-036 rr_arbiter ports: clk, rst, req[NUM_PE], advance, gnt one-hot[NUM_PE], gnt_idx, with the registered pointer inside it.
REQ-037 Counters and the output register SHALL live in pe_arbiter.

Verification
REQ-038 Reset check: hold rst 3 cycles, then release -> o_data_valid = 0, o_count = 0, o_data_ready = 0 during rst.
REQ-039 Contention: all 4 ports valid, flits {8'hk, 24'ha5a5a5}, i_data_ready = 1 -> o_src sequence 0,1,2,3,0,1..., one flit per cycle after 1-cycle latency.
REQ-040 Backpressure: i_data_ready = 0 for 5 cycles with port 2 valid -> o_data held at port 2's flit, o_data_ready = 0.
REQ-041 Backpressure release: after REQ-040, raise i_data_ready -> port 2's flit drained, then the next flit granted the same cycle.
REQ-042 Fairness skip: ports 1 and 3 valid only, last = 1 -> grant 3, then 1, then 3.
REQ-043 Saturation: CNT_W = 4, 20 flits from port 0 -> o_count port 0 = 4'hF.
REQ-044 Mid-transfer reset: assert rst while o_data_valid = 1 and i_data_ready = 0 -> next cycle o_data_valid = 0; the first post-reset grant goes to port 0.
